user_mem_responder: RTL and testbench

Responder end of the CPU memory path in the user project area. Accepts native picorv32 memory requests (mem_valid/mem_ready) and Caravel Wishbone slave cycles (management SoC access to the user RAM). Arbitrates between the two, drives the single-port DFFRAM512x32 macro (EN0/WE0/A0/Di0/Do0), and returns mem_ready/mem_rdata or wbs_ack_o/wbs_dat_o. Fixed 2-cycle request-to-response latency.

---
 rtl/user_mem_responder.sv | 149 ++++++++++++++
 tb/tb_user_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_mem_responder.sv
// Single-port DFFRAM responder shared by the picorv32 native memory bus and the
// Caravel Wishbone slave port. Every access runs IDLE -> ACC -> RESP.
module user_mem_responder #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter logic [31:0] WB_BASE    = 32'h3000_0000
) (
   input  logic                  wb_clk_i,
   input  logic                  resetn,

   input  logic                  mem_valid,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [3:0]            mem_wstrb,
   output logic                  mem_ready,
   output logic [31:0]           mem_rdata,
   output logic                  mem_err,

   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [31:0]           wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic [31:0]           wbs_dat_o,

   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   localparam logic [31:0] WIN_BYTES = 32'd4 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

   state_t                state_q, state_d;
   logic                  last_wb_q, last_wb_d;
   logic                  gnt_wb_q, gnt_wb_d;
   logic                  oob_q, oob_d;
   logic                  rd_pass_q, rd_pass_d;
   logic                  ram_en_q, ram_en_d;
   logic [3:0]            ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]           ram_wdata_q, ram_wdata_d;
   logic                  mem_ready_q, mem_ready_d;
   logic                  mem_err_q, mem_err_d;
   logic                  wbs_ack_q, wbs_ack_d;

   logic [31:0] wb_off;
   logic        cpu_req, cpu_oob, wb_req, pick_wb;

   // Unsigned offset wraps for addresses below WB_BASE, so one compare covers both bounds.
   assign wb_off  = wbs_adr_i - WB_BASE;
   assign cpu_req = mem_valid;
   assign cpu_oob = (mem_addr >= WIN_BYTES);
   assign wb_req  = wbs_cyc_i & wbs_stb_i & (wb_off < WIN_BYTES);
   assign pick_wb = wb_req & (~cpu_req | ~last_wb_q);

   always_ff @(posedge wb_clk_i) begin
      if (!resetn) begin
         state_q     <= IDLE;
         last_wb_q   <= 1'b1;
         gnt_wb_q    <= 1'b0;
         oob_q       <= 1'b0;
         rd_pass_q   <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 4'h0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'h0;
         mem_ready_q <= 1'b0;
         mem_err_q   <= 1'b0;
         wbs_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_wb_q   <= last_wb_d;
         gnt_wb_q    <= gnt_wb_d;
         oob_q       <= oob_d;
         rd_pass_q   <= rd_pass_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         mem_ready_q <= mem_ready_d;
         mem_err_q   <= mem_err_d;
         wbs_ack_q   <= wbs_ack_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_wb_d   = last_wb_q;
      gnt_wb_d    = gnt_wb_q;
      oob_d       = oob_q;
      rd_pass_d   = rd_pass_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 4'h0;
      ram_addr_d  = '0;
      ram_wdata_d = 32'h0;
      mem_ready_d = 1'b0;
      mem_err_d   = 1'b0;
      wbs_ack_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req | wb_req) begin
               state_d   = ACC;
               last_wb_d = pick_wb;
               gnt_wb_d  = pick_wb;
               if (pick_wb) begin
                  oob_d       = 1'b0;
                  rd_pass_d   = ~wbs_we_i;
                  ram_en_d    = 1'b1;
                  ram_we_d    = wbs_we_i ? wbs_sel_i : 4'h0;
                  ram_addr_d  = wbs_adr_i[ADDR_WIDTH+1:2];
                  ram_wdata_d = wbs_dat_i;
               end else begin
                  oob_d       = cpu_oob;
                  rd_pass_d   = (mem_wstrb == 4'h0) & ~cpu_oob;
                  ram_en_d    = ~cpu_oob;
                  ram_we_d    = mem_wstrb;
                  ram_addr_d  = mem_addr[ADDR_WIDTH+1:2];
                  ram_wdata_d = mem_wdata;
               end
            end
         end
         ACC: begin
            state_d     = RESP;
            mem_ready_d = ~gnt_wb_q;
            mem_err_d   = ~gnt_wb_q & oob_q;
            wbs_ack_d   = gnt_wb_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // RAM read data only arrives in RESP, so the data outputs are gated combinationally.
   assign mem_ready = mem_ready_q;
   assign mem_err   = mem_err_q;
   assign mem_rdata = (mem_ready_q & rd_pass_q) ? ram_rdata : 32'h0;
   assign wbs_ack_o = wbs_ack_q;
   assign wbs_dat_o = (wbs_ack_q & rd_pass_q) ? ram_rdata : 32'h0;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_user_mem_responder.sv
// Bench for user_mem_responder: directed scenarios plus randomized CPU/WB traffic
// scored every cycle against a transaction-level model with its own memory image.
module tb_user_mem_responder;

   localparam logic [31:0] WB_BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_ready, mem_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [8:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'h0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   user_mem_responder #(.ADDR_WIDTH(9), .WB_BASE(WB_BASE)) dut (
      .wb_clk_i(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Behavioural DFFRAM512x32: output register updates only on enabled cycles.
   logic [31:0] bram [512] = '{default: 32'h0};
   always @(posedge clk) begin
      if (ram_en) begin
         bram[ram_addr] <= merge(bram[ram_addr], ram_wdata, ram_we);
         ram_rdata      <= bram[ram_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding transaction at a time, granted cycle g,
   // RAM strobe in g+1, response in g+2; free again from g+3.
   logic [31:0] mm [512] = '{default: 32'h0};
   logic        m_ok, m_act, m_last_wb, m_wb, m_oob, m_write;
   logic [3:0]  m_we;
   logic [8:0]  m_addr;
   logic [31:0] m_wd;
   int          m_cyc, m_acc;
   logic        e_en, e_ready, e_err, e_ack;
   logic [3:0]  e_we;
   logic [8:0]  e_addr;
   logic [31:0] e_wd, e_rdata, e_wdat;

   initial begin : scoreboard
      logic cpu_r, wb_r, take_wb;
      m_ok = 0; m_act = 0; m_last_wb = 1; m_cyc = 0; m_acc = 0;
      forever begin
         @(negedge clk);
         if (m_ok) begin
            chk("ram_en", 32'(ram_en), 32'(e_en));
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_wdata", ram_wdata, e_wd);
            chk("mem_ready", 32'(mem_ready), 32'(e_ready));
            chk("mem_err", 32'(mem_err), 32'(e_err));
            chk("mem_rdata", mem_rdata, e_rdata);
            chk("wbs_ack_o", 32'(wbs_ack_o), 32'(e_ack));
            chk("wbs_dat_o", wbs_dat_o, e_wdat);
         end
         // step to the next cycle using the inputs the DUT will sample
         m_cyc++;
         if (m_act && (m_cyc - 1 == m_acc) && !m_oob)
            mm[m_addr] = merge(mm[m_addr], m_wd, m_we);
         if (!resetn) begin
            m_act = 0; m_last_wb = 1; m_ok = 1;
         end else if (!m_act || (m_cyc - 1 > m_acc + 1)) begin
            cpu_r = mem_valid;
            wb_r  = wbs_cyc_i && wbs_stb_i && (wbs_adr_i >= WB_BASE) && (wbs_adr_i < WB_BASE + 32'd2048);
            if (cpu_r || wb_r) begin
               if (cpu_r && wb_r) take_wb = !m_last_wb;
               else               take_wb = wb_r;
               m_act = 1; m_acc = m_cyc; m_last_wb = take_wb; m_wb = take_wb;
               if (take_wb) begin
                  m_oob = 0; m_write = wbs_we_i; m_we = wbs_we_i ? wbs_sel_i : 4'h0;
                  m_addr = 9'((wbs_adr_i - WB_BASE) >> 2); m_wd = wbs_dat_i;
               end else begin
                  m_oob = (mem_addr >= 32'd2048); m_write = (mem_wstrb != 4'h0); m_we = mem_wstrb;
                  m_addr = 9'(mem_addr >> 2); m_wd = mem_wdata;
               end
            end
         end
         e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
         e_ready = 0; e_err = 0; e_rdata = 0; e_ack = 0; e_wdat = 0;
         if (m_act && m_cyc == m_acc) begin
            e_en = !m_oob; e_we = m_we; e_addr = m_addr; e_wd = m_wd;
         end
         if (m_act && m_cyc == m_acc + 1) begin
            if (m_wb) begin
               e_ack = 1; e_wdat = m_write ? 32'h0 : mm[m_addr];
            end else begin
               e_ready = 1; e_err = m_oob;
               e_rdata = (m_write || m_oob) ? 32'h0 : mm[m_addr];
            end
         end
      end
   end

   task automatic cpu_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int lat, output logic [31:0] rd, output logic er,
                             output int en_c, output logic [8:0] ea, output logic [3:0] ewe);
      mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_valid = 1;
      lat = -1; rd = 0; er = 0; en_c = -1; ea = 0; ewe = 0;
      for (int i = 1; i <= 8 && lat < 0; i++) begin
         @(posedge clk); #1;
         if (ram_en && en_c < 0) begin en_c = i; ea = ram_addr; ewe = ram_we; end
         if (mem_ready) begin lat = i; rd = mem_rdata; er = mem_err; end
      end
      mem_valid = 0;
      @(posedge clk); #1;
   endtask

   task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic we,
                            input logic [3:0] sel, output int lat, output logic [31:0] rd,
                            output int en_c, output logic [8:0] ea);
      wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = we; wbs_sel_i = sel; wbs_cyc_i = 1; wbs_stb_i = 1;
      lat = -1; rd = 0; en_c = -1; ea = 0;
      for (int i = 1; i <= 8 && lat < 0; i++) begin
         @(posedge clk); #1;
         if (ram_en && en_c < 0) begin en_c = i; ea = ram_addr; end
         if (wbs_ack_o) begin lat = i; rd = wbs_dat_o; end
      end
      wbs_cyc_i = 0; wbs_stb_i = 0;
      @(posedge clk); #1;
   endtask

   initial begin : stim
      int lat, en_c, cpu_en, wb_en, rdy_c, ack_c, wb_age;
      logic [31:0] rd, cpu_rd, wb_rd;
      logic er, wb_oob;
      logic [8:0] ea;
      logic [3:0] ewe;
      int unsigned w;

      resetn = 0;
      mem_valid = 1; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;

      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_ram_en", 32'(ram_en), 32'd0);
         chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      end
      resetn = 1;
      @(posedge clk); #1;
      chk("rst_release_en", 32'(ram_en), 32'd1);
      @(posedge clk); #1;
      chk("rst_release_ready", 32'(mem_ready), 32'd1);
      mem_valid = 0;
      @(posedge clk); #1;

      cpu_access(32'h0000_0010, 32'hCAFE_BABE, 4'hF, lat, rd, er, en_c, ea, ewe);
      chk("cpu_wr_lat", 32'(lat), 32'd2);
      chk("cpu_wr_en_cycle", 32'(en_c), 32'd1);
      chk("cpu_wr_addr", 32'(ea), 32'd4);
      chk("cpu_wr_we", 32'(ewe), 32'hF);
      chk("model_word4", mm[4], 32'hCAFE_BABE);
      cpu_access(32'h0000_0010, 32'h0, 4'h0, lat, rd, er, en_c, ea, ewe);
      chk("cpu_rd_lat", 32'(lat), 32'd2);
      chk("cpu_rd_data", rd, 32'hCAFE_BABE);

      cpu_access(32'h0000_0010, 32'h0000_AB00, 4'b0010, lat, rd, er, en_c, ea, ewe);
      chk("byte_wr_lat", 32'(lat), 32'd2);
      cpu_access(32'h0000_0010, 32'h0, 4'h0, lat, rd, er, en_c, ea, ewe);
      chk("byte_rd_data", rd, 32'hCAFE_ABBE);
      chk("model_word4_byte", mm[4], 32'hCAFE_ABBE);

      wb_access(32'h3000_07FC, 32'h1234_5678, 1'b1, 4'hF, lat, rd, en_c, ea);
      chk("wb_wr_ack_lat", 32'(lat), 32'd2);
      chk("wb_wr_addr", 32'(ea), 32'd511);
      chk("wb_wr_dat_gated", rd, 32'h0);
      cpu_access(32'h0000_07FC, 32'h0, 4'h0, lat, rd, er, en_c, ea, ewe);
      chk("cpu_rd_7fc", rd, 32'h1234_5678);
      wb_access(32'h3000_0800, 32'h0, 1'b0, 4'hF, lat, rd, en_c, ea);
      chk("wb_oob_noack", 32'(lat < 0), 32'd1);
      chk("wb_oob_no_en", 32'(en_c < 0), 32'd1);

      cpu_access(32'h0000_0800, 32'h0, 4'h0, lat, rd, er, en_c, ea, ewe);
      chk("cpu_oob_lat", 32'(lat), 32'd2);
      chk("cpu_oob_err", 32'(er), 32'd1);
      chk("cpu_oob_rdata", rd, 32'h0);
      chk("cpu_oob_no_en", 32'(en_c < 0), 32'd1);

      // Simultaneous CPU and WB reads straight out of reset
      resetn = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1;
      mem_addr = 32'h0000_07FC; mem_wstrb = 4'h0; mem_valid = 1;
      wbs_adr_i = 32'h3000_0010; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_cyc_i = 1; wbs_stb_i = 1;
      cpu_en = -1; wb_en = -1; rdy_c = -1; ack_c = -1; cpu_rd = 0; wb_rd = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (ram_en) begin
            if (cpu_en < 0) cpu_en = i;
            else if (wb_en < 0) wb_en = i;
         end
         if (mem_ready) begin rdy_c = i; cpu_rd = mem_rdata; mem_valid = 0; end
         if (wbs_ack_o) begin ack_c = i; wb_rd = wbs_dat_o; wbs_cyc_i = 0; wbs_stb_i = 0; end
      end
      mem_valid = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
      chk("tie_cpu_en", 32'(cpu_en), 32'd1);
      chk("tie_cpu_ready", 32'(rdy_c), 32'd2);
      chk("tie_cpu_data", cpu_rd, 32'h1234_5678);
      chk("tie_wb_en", 32'(wb_en), 32'd4);
      chk("tie_wb_ack", 32'(ack_c), 32'd5);
      chk("tie_wb_data", wb_rd, 32'hCAFE_ABBE);

      wb_age = 0; wb_oob = 0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         if (!resetn) resetn = 1;
         else if ($urandom_range(0, 249) == 0) resetn = 0;

         if (mem_valid && mem_ready) mem_valid = 0;
         else if (mem_valid && $urandom_range(0, 7) == 0) mem_wdata = $urandom;
         if (!mem_valid && $urandom_range(0, 2) == 0) begin
            mem_valid = 1;
            mem_wdata = $urandom;
            mem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) mem_addr = 32'h800 + $urandom_range(0, 4095);
            else begin
               w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 15);
               mem_addr = (w << 2) | $urandom_range(0, 3);
            end
         end

         if (wbs_stb_i && wbs_ack_o) begin wbs_cyc_i = 0; wbs_stb_i = 0; end
         else if (wbs_stb_i && wb_oob) begin
            wb_age++;
            if (wb_age > 5) begin wbs_cyc_i = 0; wbs_stb_i = 0; end
         end
         if (!wbs_stb_i && $urandom_range(0, 2) == 0) begin
            wbs_cyc_i = 1; wbs_stb_i = 1; wb_age = 0;
            wbs_we_i = 1'($urandom_range(0, 1));
            wbs_sel_i = 4'($urandom_range(0, 15));
            wbs_dat_i = $urandom;
            wb_oob = ($urandom_range(0, 6) == 0);
            if (wb_oob)
               wbs_adr_i = ($urandom_range(0, 1) == 0) ? WB_BASE + 32'h800 + $urandom_range(0, 255)
                                                       : WB_BASE - 32'd1 - $urandom_range(0, 255);
            else begin
               w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 15);
               wbs_adr_i = WB_BASE + ((w << 2) | $urandom_range(0, 3));
            end
         end
      end

      mem_valid = 0; wbs_cyc_i = 0; wbs_stb_i = 0; resetn = 1;
      repeat (6) begin @(posedge clk); #1; end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
